// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO control engine.
package fifo_pkg;

    localparam int unsigned FIFO_S     = 8;
    localparam int unsigned FIFO_DEPTH = 90;

    // Distance of the almost_full / almost_empty thresholds from the ends.
    localparam int unsigned AF_MARGIN  = 4;
    localparam int unsigned AE_MARGIN  = 4;

    // Pointer increment with wrap at depth-1, so depth need not be a power of two.
    function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request strobes, memory address/enable and status of the FIFO control engine.
interface fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int unsigned S = FIFO_S
);

    logic         wr_req;
    logic         rd_req;
    logic         wren;
    logic [S-1:0] wrptr;
    logic [S-1:0] rdptr;
    logic         rd_valid;
    logic [S:0]   count;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic         overflow;
    logic         underflow;

    // Producer/consumer side: issues requests, observes memory control and status.
    modport master (
        output wr_req, rd_req,
        input  wren, wrptr, rdptr, rd_valid, count,
        input  full, empty, almost_full, almost_empty, overflow, underflow
    );

    // Controller side.
    modport slave (
        input  wr_req, rd_req,
        output wren, wrptr, rdptr, rd_valid, count,
        output full, empty, almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr_wrap.sv
// Registered pointer that advances on inc and wraps from DEPTH-1 back to 0.
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter int unsigned S     = FIFO_S,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [S-1:0] ptr_q
);

    logic [S-1:0] ptr_nxt;

    // Next pointer value: hold, or step with non-power-of-two wrap.
    always_comb begin
        ptr_nxt = ptr_q;
        if (inc) begin
            ptr_nxt = S'(next_ptr(32'(ptr_q), DEPTH));
        end
    end

    // Pointer register, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO control engine: pointers, occupancy, status flags and sticky
// error bits for a registered-read storage array. Holds no data itself.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned S      = FIFO_S,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned AF_LVL = DEPTH - AF_MARGIN,
    parameter int unsigned AE_LVL = AE_MARGIN
) (
    input  logic       clk,
    input  logic       rst,
    fifo_ctrl_if.slave bus
);

    localparam logic [S:0] CNT_ONE   = (S+1)'(1);
    localparam logic [S:0] CNT_DEPTH = (S+1)'(DEPTH);
    localparam logic [S:0] CNT_AF    = (S+1)'(AF_LVL);
    localparam logic [S:0] CNT_AE    = (S+1)'(AE_LVL);

    logic         wr_acc;
    logic         rd_acc;
    logic [S:0]   count_q;
    logic [S:0]   count_nxt;
    logic [S-1:0] wrptr_q;
    logic [S-1:0] rdptr_q;
    logic         full_q;
    logic         empty_q;
    logic         af_q;
    logic         ae_q;
    logic         rv_q;
    logic         ovf_q;
    logic         unf_q;

    // Request qualification from registered flags only, never same-cycle requests.
    always_comb begin
        wr_acc = bus.wr_req & ~full_q;
        rd_acc = bus.rd_req & ~empty_q;
    end

    fifo_ptr_wrap #(
        .S     (S),
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (wr_acc),
        .ptr_q (wrptr_q)
    );

    fifo_ptr_wrap #(
        .S     (S),
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (rd_acc),
        .ptr_q (rdptr_q)
    );

    // Next occupancy: +1 on write only, -1 on read only, unchanged otherwise.
    always_comb begin
        count_nxt = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + CNT_ONE;
            2'b01:   count_nxt = count_q - CNT_ONE;
            default: count_nxt = count_q;
        endcase
    end

    // Occupancy and flags share one edge; flags derive from next count so they
    // always agree with the registered count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNT_DEPTH);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= CNT_AF);
            ae_q    <= (count_nxt <= CNT_AE);
        end
    end

    // Read-data valid follows an accepted read by one clock; error bits are sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            rv_q  <= rd_acc;
            ovf_q <= ovf_q | (bus.wr_req & full_q);
            unf_q <= unf_q | (bus.rd_req & empty_q);
        end
    end

    assign bus.wren         = wr_acc;
    assign bus.wrptr        = wrptr_q;
    assign bus.rdptr        = rdptr_q;
    assign bus.rd_valid     = rv_q;
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule
